// File: rtl/cr16_datapath.sv
// cr16_datapath: CompactRISC16 register file, operand-A immediate mux, 15-op ALU and write-back mux.
// Build option: define CR16_DATAPATH_MUL_EN to give opcode 6 a signed 16x16 multiplier (low half).
module cr16_datapath (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_ENABLE,
   input  logic [15:0] I_REG_WRITE_ENABLE,
   input  logic [3:0]  I_REG_A_SELECT,
   input  logic [3:0]  I_REG_B_SELECT,
   input  logic        I_IMMEDIATE_SELECT,
   input  logic [15:0] I_IMMEDIATE,
   input  logic [3:0]  I_OPCODE,
   input  logic [15:0] I_REG_DATA,
   input  logic        I_REG_DATA_SELECT,
   output logic [15:0] O_A,
   output logic [15:0] O_B,
   output logic [15:0] O_RESULT_BUS,
   output logic [4:0]  O_STATUS_FLAGS
);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_ADDU  = 4'd1;
   localparam logic [3:0] OP_ADDC  = 4'd2;
   localparam logic [3:0] OP_ADDCU = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_SUBU  = 4'd5;
   localparam logic [3:0] OP_AND   = 4'd7;
   localparam logic [3:0] OP_OR    = 4'd8;
   localparam logic [3:0] OP_XOR   = 4'd9;
   localparam logic [3:0] OP_NOT   = 4'd10;
   localparam logic [3:0] OP_LSH   = 4'd11;
   localparam logic [3:0] OP_RSH   = 4'd12;
   localparam logic [3:0] OP_ALSH  = 4'd13;
   localparam logic [3:0] OP_ARSH  = 4'd14;
`ifdef CR16_DATAPATH_MUL_EN
   localparam logic [3:0] OP_MUL   = 4'd6;
`endif

   logic [15:0] r_regs [16];
   logic        r_carry;

   logic [15:0] w_op_a;
   logic [15:0] w_op_b;
   logic        w_cin;
   logic [16:0] w_sum;
   logic [16:0] w_diff;
   logic        w_add_ovf;
   logic        w_sub_ovf;
   logic        w_lt_u;
   logic        w_lt_s;
   logic [3:0]  w_shamt;
   logic [15:0] w_shl;
   logic [15:0] w_shr;
   logic [15:0] w_sar;
`ifdef CR16_DATAPATH_MUL_EN
   logic [15:0] w_prod;
`endif
   logic [15:0] w_alu;
   logic        w_c;
   logic        w_f;
   logic        w_op_valid;
   logic        w_zero;
   logic        w_carry_load;

   // Reads are straight from the array: a register written this cycle shows its old value.
   assign O_A    = r_regs[I_REG_A_SELECT];
   assign O_B    = r_regs[I_REG_B_SELECT];
   assign w_op_a = I_IMMEDIATE_SELECT ? I_IMMEDIATE : O_A;
   assign w_op_b = O_B;

   assign w_cin     = ((I_OPCODE == OP_ADDC) || (I_OPCODE == OP_ADDCU)) && r_carry;
   assign w_sum     = {1'b0, w_op_a} + {1'b0, w_op_b} + {16'd0, w_cin};
   assign w_diff    = {1'b0, w_op_a} - {1'b0, w_op_b};
   assign w_add_ovf = (w_op_a[15] == w_op_b[15]) && (w_sum[15] != w_op_a[15]);
   assign w_sub_ovf = (w_op_a[15] != w_op_b[15]) && (w_diff[15] != w_op_a[15]);
   assign w_lt_u    = w_diff[16];
   assign w_lt_s    = $signed(w_op_a) < $signed(w_op_b);

   assign w_shamt = w_op_b[3:0];
   assign w_shl   = w_op_a << w_shamt;
   assign w_shr   = w_op_a >> w_shamt;
   assign w_sar   = $signed(w_op_a) >>> w_shamt;

`ifdef CR16_DATAPATH_MUL_EN
   // Low half of a product is the same for signed and unsigned operands.
   assign w_prod = w_op_a * w_op_b;
`endif

   always_comb begin
      w_alu      = 16'd0;
      w_c        = 1'b0;
      w_f        = 1'b0;
      w_op_valid = 1'b1;
      case (I_OPCODE)
         OP_ADD, OP_ADDC: begin
            w_alu = w_sum[15:0];
            w_c   = w_sum[16];
            w_f   = w_add_ovf;
         end
         OP_ADDU, OP_ADDCU: begin
            w_alu = w_sum[15:0];
            w_c   = w_sum[16];
         end
         OP_SUB: begin
            w_alu = w_diff[15:0];
            w_c   = w_lt_u;
            w_f   = w_sub_ovf;
         end
         OP_SUBU: begin
            w_alu = w_diff[15:0];
            w_c   = w_lt_u;
         end
`ifdef CR16_DATAPATH_MUL_EN
         OP_MUL:  w_alu = w_prod;
`endif
         OP_AND:  w_alu = w_op_a & w_op_b;
         OP_OR:   w_alu = w_op_a | w_op_b;
         OP_XOR:  w_alu = w_op_a ^ w_op_b;
         OP_NOT:  w_alu = ~w_op_a;
         OP_LSH, OP_ALSH: w_alu = w_shl;
         OP_RSH:  w_alu = w_shr;
         OP_ARSH: w_alu = w_sar;
         default: w_op_valid = 1'b0;
      endcase
   end

   assign w_zero = (w_alu == 16'd0);

   // Reserved opcodes report no flags at all, Z included.
   assign O_STATUS_FLAGS = w_op_valid ? {w_c, w_lt_u, w_f, w_zero, w_lt_s} : 5'd0;
   assign O_RESULT_BUS   = I_REG_DATA_SELECT ? I_REG_DATA : w_alu;

   assign w_carry_load = !I_REG_DATA_SELECT && (I_OPCODE <= OP_SUBU);

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         for (int i = 0; i < 16; i++) r_regs[i] <= 16'd0;
         r_carry <= 1'b0;
      end else if (I_ENABLE) begin
         for (int i = 0; i < 16; i++) begin
            if (I_REG_WRITE_ENABLE[i]) r_regs[i] <= O_RESULT_BUS;
         end
         if (w_carry_load) r_carry <= w_c;
      end
   end

endmodule

// File: tb/tb_cr16_datapath.sv
// Self-checking bench for cr16_datapath: directed literal checks plus randomized traffic
// compared every cycle against an integer-arithmetic model of the register file and ALU.
module tb_cr16_datapath;

   logic        I_CLK = 1'b0;
   logic        I_RESET;
   logic        I_ENABLE;
   logic [15:0] I_REG_WRITE_ENABLE;
   logic [3:0]  I_REG_A_SELECT;
   logic [3:0]  I_REG_B_SELECT;
   logic        I_IMMEDIATE_SELECT;
   logic [15:0] I_IMMEDIATE;
   logic [3:0]  I_OPCODE;
   logic [15:0] I_REG_DATA;
   logic        I_REG_DATA_SELECT;
   logic [15:0] O_A;
   logic [15:0] O_B;
   logic [15:0] O_RESULT_BUS;
   logic [4:0]  O_STATUS_FLAGS;

   cr16_datapath dut (
      .I_CLK(I_CLK), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE),
      .I_REG_WRITE_ENABLE(I_REG_WRITE_ENABLE),
      .I_REG_A_SELECT(I_REG_A_SELECT), .I_REG_B_SELECT(I_REG_B_SELECT),
      .I_IMMEDIATE_SELECT(I_IMMEDIATE_SELECT), .I_IMMEDIATE(I_IMMEDIATE),
      .I_OPCODE(I_OPCODE), .I_REG_DATA(I_REG_DATA),
      .I_REG_DATA_SELECT(I_REG_DATA_SELECT),
      .O_A(O_A), .O_B(O_B), .O_RESULT_BUS(O_RESULT_BUS),
      .O_STATUS_FLAGS(O_STATUS_FLAGS)
   );

   always #5 I_CLK = ~I_CLK;

   int n_cmp = 0;
   int n_err = 0;
   int m_reg [16];
   int m_carry;

   function automatic int sx(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   // Flag word packed as C*16 + L*8 + F*4 + Z*2 + N.
   function automatic void model_alu(input int a, input int b, input int op, input int cin,
                                     output int res, output int fl);
      int s, c, f, valid;
      c = 0; f = 0; res = 0; valid = 1;
      case (op)
         0, 1, 2, 3: begin
            s   = a + b + ((op >= 2) ? cin : 0);
            res = s & 'hFFFF;
            c   = (s > 65535) ? 1 : 0;
            if (op == 0 || op == 2) begin
               s = sx(a) + sx(b) + ((op == 2) ? cin : 0);
               f = (s > 32767 || s < -32768) ? 1 : 0;
            end
         end
         4, 5: begin
            res = (a - b) & 'hFFFF;
            c   = (a < b) ? 1 : 0;
            if (op == 4) begin
               s = sx(a) - sx(b);
               f = (s > 32767 || s < -32768) ? 1 : 0;
            end
         end
`ifdef CR16_DATAPATH_MUL_EN
         6:  res = (sx(a) * sx(b)) & 'hFFFF;
`endif
         7:  res = a & b;
         8:  res = a | b;
         9:  res = a ^ b;
         10: res = (~a) & 'hFFFF;
         11, 13: res = (a << (b % 16)) & 'hFFFF;
         12: res = a >> (b % 16);
         14: res = (sx(a) >>> (b % 16)) & 'hFFFF;
         default: valid = 0;
      endcase
      if (valid == 0) begin
         res = 0;
         fl  = 0;
      end else begin
         fl = c * 16 + ((a < b) ? 8 : 0) + f * 4 + ((res == 0) ? 2 : 0)
              + ((sx(a) < sx(b)) ? 1 : 0);
      end
   endfunction

   function automatic void model_now(output int res, output int fl, output int bus);
      int a, b;
      a = I_IMMEDIATE_SELECT ? int'(I_IMMEDIATE) : m_reg[I_REG_A_SELECT];
      b = m_reg[I_REG_B_SELECT];
      model_alu(a, b, int'(I_OPCODE), m_carry, res, fl);
      bus = I_REG_DATA_SELECT ? int'(I_REG_DATA) : res;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [3:0] asel, input logic [3:0] bsel, input logic isel,
                         input logic [15:0] imm, input logic [3:0] opc, input logic dsel,
                         input logic [15:0] rdata, input logic [15:0] we, input logic en);
      I_REG_A_SELECT     = asel;
      I_REG_B_SELECT     = bsel;
      I_IMMEDIATE_SELECT = isel;
      I_IMMEDIATE        = imm;
      I_OPCODE           = opc;
      I_REG_DATA_SELECT  = dsel;
      I_REG_DATA         = rdata;
      I_REG_WRITE_ENABLE = we;
      I_ENABLE           = en;
   endtask

   task automatic tick();
      int res, fl, bus;
      @(posedge I_CLK);
      if (I_RESET) begin
         for (int i = 0; i < 16; i++) m_reg[i] = 0;
         m_carry = 0;
      end else if (I_ENABLE) begin
         model_now(res, fl, bus);
         for (int i = 0; i < 16; i++) if (I_REG_WRITE_ENABLE[i]) m_reg[i] = bus;
         if (!I_REG_DATA_SELECT && I_OPCODE <= 4'd5) m_carry = (fl >> 4) & 1;
      end
      #1;
   endtask

   always @(negedge I_CLK) begin
      int res, fl, bus;
      model_now(res, fl, bus);
      check("o_a",    O_A,            m_reg[I_REG_A_SELECT]);
      check("o_b",    O_B,            m_reg[I_REG_B_SELECT]);
      check("bus",    O_RESULT_BUS,   bus);
      check("flags",  O_STATUS_FLAGS, fl);
   end

   initial begin
      int fa, fb, fn;
      logic [15:0] we;
      I_RESET = 1'b1;
      for (int i = 0; i < 16; i++) m_reg[i] = 0;
      m_carry = 0;
      set_in(4'd5, 4'd9, 1'b0, 16'h1234, 4'd0, 1'b0, 16'h0, 16'hFFFF, 1'b1);
      #3;
      check("rst_a", O_A, 0);
      check("rst_b", O_B, 0);
      tick();
      I_RESET = 1'b0;

      set_in(4'd0, 4'd0, 1'b1, 16'd7, 4'd0, 1'b0, 16'h0, 16'h0001, 1'b1);
      #2; check("ld7", O_RESULT_BUS, 7); tick();
      set_in(4'd0, 4'd2, 1'b1, 16'd4, 4'd0, 1'b0, 16'h0, 16'h0002, 1'b1);
      #2; check("ld4", O_RESULT_BUS, 4); tick();
      set_in(4'd0, 4'd1, 1'b0, 16'h0, 4'd7, 1'b0, 16'h0, 16'h0, 1'b1);
      #2; check("r0", O_A, 7); check("r1", O_B, 4); check("and", O_RESULT_BUS, 4); tick();
      I_OPCODE = 4'd8;  #2; check("or",  O_RESULT_BUS, 7); tick();
      I_OPCODE = 4'd9;  #2; check("xor", O_RESULT_BUS, 3); tick();
      I_OPCODE = 4'd10; #2; check("not", O_RESULT_BUS, 'hFFF8); tick();

      set_in(4'd0, 4'd2, 1'b1, 16'd0, 4'd0, 1'b0, 16'h0, 16'h0001, 1'b1); tick();
      set_in(4'd0, 4'd2, 1'b1, 16'd1, 4'd0, 1'b0, 16'h0, 16'h0002, 1'b1); tick();
      set_in(4'd0, 4'd1, 1'b0, 16'h0, 4'd4, 1'b0, 16'h0, 16'h0, 1'b1);
      #2;
      check("sub",   O_RESULT_BUS, 'hFFFF);
      check("sub_c", O_STATUS_FLAGS[4], 1);
      check("sub_l", O_STATUS_FLAGS[3], 1);
      check("sub_z", O_STATUS_FLAGS[1], 0);
      tick();
      set_in(4'd0, 4'd1, 1'b1, 16'h7FFF, 4'd0, 1'b0, 16'h0, 16'h0, 1'b1);
      #2; check("add_ovf", O_RESULT_BUS, 'h8000); check("add_f", O_STATUS_FLAGS[2], 1); tick();

      fa = 0; fb = 1;
      for (int i = 0; i < 14; i++) begin
         fn = fa + fb;
         we = 16'(1 << (i + 2));
         set_in(4'(i), 4'(i + 1), 1'b0, 16'h0, 4'd0, 1'b0, 16'h0, we, 1'b1);
         #2; check("fib", O_RESULT_BUS, fn); tick();
         fa = fb; fb = fn;
      end
      set_in(4'd15, 4'd14, 1'b0, 16'h0, 4'd7, 1'b0, 16'h0, 16'h0, 1'b1);
      #2; check("r15", O_A, 610); tick();

      set_in(4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b1, 16'd5, 16'h0001, 1'b1);
      #2; check("rd5", O_RESULT_BUS, 5); tick();
      set_in(4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b1, 16'd6, 16'h0002, 1'b1);
      #2; check("rd6", O_RESULT_BUS, 6); tick();
      set_in(4'd0, 4'd1, 1'b0, 16'h0, 4'd0, 1'b0, 16'h0, 16'h0004, 1'b1);
      #2; check("add11", O_RESULT_BUS, 11); tick();

      set_in(4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b1, 16'd1, 16'h0008, 1'b1); tick();
      set_in(4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b1, 16'd0, 16'h0010, 1'b1); tick();
      set_in(4'd0, 4'd3, 1'b1, 16'hFFFF, 4'd1, 1'b0, 16'h0, 16'h0, 1'b1);
      #2;
      check("addu",   O_RESULT_BUS, 0);
      check("addu_c", O_STATUS_FLAGS[4], 1);
      check("addu_z", O_STATUS_FLAGS[1], 1);
      tick();
      set_in(4'd0, 4'd4, 1'b1, 16'h0, 4'd5, 1'b1, 16'h1234, 16'hFFFF, 1'b0); tick();
      set_in(4'd0, 4'd4, 1'b1, 16'h0, 4'd2, 1'b0, 16'h0, 16'h0, 1'b1);
      #2; check("addc", O_RESULT_BUS, 1); check("hold_r0", O_A, 5); tick();

      set_in(4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b1, 16'd4, 16'h0020, 1'b1); tick();
      set_in(4'd0, 4'd5, 1'b1, 16'h8000, 4'd14, 1'b0, 16'h0, 16'h0, 1'b1);
      #2; check("arsh", O_RESULT_BUS, 'hF800); tick();
      I_OPCODE = 4'd12; #2; check("rsh", O_RESULT_BUS, 'h0800); tick();
      I_OPCODE = 4'd11; I_IMMEDIATE = 16'h8001;
      #2; check("lsh", O_RESULT_BUS, 'h0010); tick();
      I_OPCODE = 4'd15; #2; check("rsv", O_STATUS_FLAGS, 0); tick();

      for (int n = 0; n < 600; n++) begin
         logic [15:0] imm;
         case ($urandom_range(0, 5))
            0: imm = 16'h0000;
            1: imm = 16'hFFFF;
            2: imm = 16'h7FFF;
            3: imm = 16'h8000;
            default: imm = 16'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: we = 16'(1 << $urandom_range(0, 15));
            1: we = 16'($urandom);
            default: we = 16'h0;
         endcase
         set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), imm, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0), 16'($urandom), we,
                ($urandom_range(0, 4) != 0));
         tick();
      end

      set_in(4'd7, 4'd3, 1'b0, 16'h0, 4'd0, 1'b1, 16'hA5A5, 16'hFFFF, 1'b1); tick();
      set_in(4'd7, 4'd3, 1'b0, 16'h0, 4'd0, 1'b1, 16'h5A5A, 16'hFFFF, 1'b1);
      #2; check("pre_rst", O_A, 'hA5A5);
      I_RESET = 1'b1;
      for (int i = 0; i < 16; i++) m_reg[i] = 0;
      m_carry = 0;
      #1; check("async_clr", O_A, 0);
      tick();
      #1; I_RESET = 1'b0; I_ENABLE = 1'b0;
      for (int i = 0; i < 16; i++) begin
         I_REG_A_SELECT = 4'(i);
         #1; check("rst_reg", O_A, 0);
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
